pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 94 +++++++++
 tb/tb_pc_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// and presents the fetched instruction to decode until it is consumed or flushed.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] target;
  logic        capture;

  assign target  = redirect_pc & ~32'd3;
  assign capture = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // S_DROP exists so a response to a redirected-away request is swallowed
  // before the next request goes out; only one request is ever in flight.
  always_comb begin
    state_next = state;
    unique case (state)
      S_REQ: begin
        if (!redirect_valid && imem_req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_next = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          state_next = S_HOLD;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_next = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid || if_ready) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == S_REQ) && !redirect_valid;
    imem_req_addr  = pc;
  end

  // A redirect always wins the pc, whatever state the fetch is in.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'd0;
      if_instr <= 32'd0;
    end else begin
      if (redirect_valid) begin
        pc <= target;
      end else if (capture) begin
        pc <= pc + 32'd4;
      end

      if (capture) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_rsp_data;
      end else if ((state == S_HOLD) && (redirect_valid || if_ready)) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: behavioural instruction memory with adjustable latency,
// a scoreboard of fetched {pc, instr} pairs, a cycle vector table and corner sequences.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        rdy;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_if_valid;
    logic [31:0] exp_if_pc;
  } vec_t;
  vec_t vecs[8];

  pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0013) + 32'h0001_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: score any consumption, then update the memory model after the edge.
  task automatic tick();
    logic        rst;
    logic        redir;
    logic        fire;
    logic        consume;
    logic [31:0] fire_addr;
    exp_t        e;
    rst       = reset;
    redir     = redirect_valid;
    fire      = imem_req_valid && imem_req_ready;
    fire_addr = imem_req_addr;
    consume   = if_valid && if_ready && !redir;
    if (!rst && consume) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got pc %h expected no instruction", if_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_instr", if_instr, e.instr);
      end
    end
    @(posedge clock);
    #1;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      sb.delete();
      mem_cnt = 0;
    end else begin
      if (redir) sb.delete();
      if (fire) begin
        mem_addr = fire_addr;
        mem_cnt  = mem_lat;
        sb.push_back('{fire_addr, mem_word(fire_addr)});
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
        end
      end
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    if_ready = v.rdy;
    #1;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("vec%0d_req_valid", idx), {31'd0, imem_req_valid}, {31'd0, v.exp_req_valid});
    check($sformatf("vec%0d_req_addr", idx), imem_req_addr, v.exp_addr);
    check($sformatf("vec%0d_if_valid", idx), {31'd0, if_valid}, {31'd0, v.exp_if_valid});
    check($sformatf("vec%0d_if_pc", idx), if_pc, v.exp_if_pc);
  endtask

  task automatic redirect_tick(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    check("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic wait_if_valid(input int max, input logic [31:0] exp_pc);
    int n = 0;
    while (!if_valid && n < max) begin
      tick();
      n++;
    end
    if (!if_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_if_valid: got timeout after %0d cycles expected pc %h", max, exp_pc);
    end else begin
      check("present_pc", if_pc, exp_pc);
      check("present_instr", if_instr, mem_word(exp_pc));
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if_ready       = 1'b1;

    // rdy, req_valid, addr, if_valid, if_pc: 1-cycle memory, one fetch per 3 cycles
    vecs[0] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h000};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 1'b0, 32'h000};
    vecs[2] = '{1'b1, 1'b0, 32'h104, 1'b1, 32'h100};
    vecs[3] = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h100};
    vecs[4] = '{1'b1, 1'b0, 32'h104, 1'b0, 32'h100};
    vecs[5] = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h104};
    vecs[6] = '{1'b1, 1'b1, 32'h108, 1'b0, 32'h104};
    vecs[7] = '{1'b1, 1'b0, 32'h108, 1'b0, 32'h104};

    tick();
    tick();
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_addr", imem_req_addr, 32'h100);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], i);
      tick();
    end

    // Decode stall while 0x108 is held
    if_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_if_valid", {31'd0, if_valid}, 32'd1);
      check("stall_if_pc", if_pc, 32'h108);
      check("stall_if_instr", if_instr, mem_word(32'h108));
      check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    if_ready = 1'b1;
    tick();
    check("resume_addr", imem_req_addr, 32'h10C);
    check("resume_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Redirect in S_WAIT, stale response arrives while draining
    mem_lat = 3;
    tick();
    redirect_tick(32'h200);
    check("drop_if_valid", {31'd0, if_valid}, 32'd0);
    check("drop_addr", imem_req_addr, 32'h200);
    check("drop_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    check("drop_rsp_if_valid", {31'd0, if_valid}, 32'd0);
    check("drop_rsp_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    check("post_drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("post_drop_addr", imem_req_addr, 32'h200);
    check("post_drop_if_valid", {31'd0, if_valid}, 32'd0);
    mem_lat = 1;
    wait_if_valid(10, 32'h200);

    // Redirect to a misaligned target while holding with if_ready=1
    redirect_tick(32'h203);
    check("flush_if_valid", {31'd0, if_valid}, 32'd0);
    check("flush_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("flush_addr", imem_req_addr, 32'h200);

    // Redirect coinciding with the response in S_WAIT
    tick();
    check("coinc_rsp_valid", {31'd0, imem_rsp_valid}, 32'd1);
    redirect_tick(32'h240);
    check("coinc_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("coinc_addr", imem_req_addr, 32'h240);
    check("coinc_if_valid", {31'd0, if_valid}, 32'd0);

    // Memory not ready: address stable, then a redirect with no request issued
    imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("mstall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("mstall_addr", imem_req_addr, 32'h240);
      tick();
    end
    imem_req_ready = 1'b1;
    redirect_tick(32'h300);
    check("mstall_redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("mstall_redir_addr", imem_req_addr, 32'h300);

    // PC wrap from the top of the address space
    redirect_tick(32'hFFFF_FFFC);
    wait_if_valid(10, 32'hFFFF_FFFC);
    tick();
    check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("wrap_addr", imem_req_addr, 32'h0);

    // Reset while a request is outstanding
    tick();
    reset = 1'b1;
    tick();
    check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("midrst_addr", imem_req_addr, 32'h100);
    check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    check("midrst_if_pc", if_pc, 32'd0);
    reset = 1'b0;
    wait_if_valid(10, 32'h100);
    tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
